// File: rtl/cordic_result_collector.sv
// Delays the polar core's in_valid by LATENCY cycles, captures r/phi into a result FIFO.
// Optional peak-magnitude tracking is enabled by defining CORDIC_PEAK_TRACK_EN.
module cordic_result_collector #(
  parameter int unsigned LATENCY = 18,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              r_in,
  input  logic [31:0]              phi_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_r,
  output logic [31:0]              out_phi,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     peak_clr,
  output logic [31:0]              peak_r
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [31:0]        mem_r_q   [DEPTH];
  logic [31:0]        mem_phi_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        count_q;
  logic               overflow_q;

  logic capture, full, push, pop, drop;

  always_comb begin
    tag_d[0] = in_valid;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign capture   = tag_q[LATENCY-1];
  assign full      = (count_q == FullCount);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a capture into a full FIFO still lands.
  assign push      = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_r_q[wptr_q]   <= r_in;
      mem_phi_q[wptr_q] <= phi_in;
    end
  end

  assign out_r    = out_valid ? mem_r_q[rptr_q]   : '0;
  assign out_phi  = out_valid ? mem_phi_q[rptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;

`ifdef CORDIC_PEAK_TRACK_EN
  logic [31:0] peak_q, peak_d;

  // An accepted push in the clear cycle wins over the clear.
  always_comb begin
    peak_d = peak_q;
    if (push && (peak_clr || ($signed(r_in) > $signed(peak_q)))) begin
      peak_d = r_in;
    end else if (peak_clr) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_r = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_r = '0;
`endif

endmodule

// File: tb/tb_cordic_result_collector.sv
// Self-checking bench for cordic_result_collector: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_cordic_result_collector;

  localparam int LAT = 18;
  localparam int DEP = 8;
  localparam int AW  = $clog2(DEP);

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, peak_clr;
  logic [31:0]   r_in, phi_in, out_r, out_phi, peak_r;
  logic          out_valid, overflow;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  cordic_result_collector #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .r_in      (r_in),
    .phi_in    (phi_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_phi   (out_phi),
    .count     (count),
    .overflow  (overflow),
    .peak_clr  (peak_clr),
    .peak_r    (peak_r)
  );

  typedef struct {
    logic [31:0] r;
    logic [31:0] phi;
  } ent_t;

  // Reference model: FIFO contents, absolute capture cycles of in-flight samples, flags.
  ent_t        mq[$];
  longint      pend[$];
  bit          m_ovf;
  logic [31:0] m_peak;
  longint      cyc;

  int vectors = 0;
  int miscompares = 0;
  longint pulse_cyc;
  longint first_valid;
  int dut_pops;
  bit saw_valid;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_ovf  = 1'b0;
    m_peak = '0;
  endtask

  // Check outputs against the model, advance the model with current inputs, clock once.
  task automatic tick();
    bit   exp_v;
    bit   cap, did_push;
    ent_t e;
    #1;
    exp_v = (mq.size() != 0);
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("out_r",     64'(out_r),     exp_v ? 64'(mq[0].r)   : 64'd0);
    chk("out_phi",   64'(out_phi),   exp_v ? 64'(mq[0].phi) : 64'd0);
    chk("count",     64'(count),     64'(mq.size()));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("peak_r",    64'(peak_r),    64'(m_peak));
    if (out_valid && first_valid < 0) first_valid = cyc - pulse_cyc;
    if (out_valid) saw_valid = 1'b1;
    if (out_valid && out_ready) dut_pops++;

    if (rst) begin
      model_reset();
    end else begin
      cap = (pend.size() > 0) && (pend[0] == cyc);
      if (cap) void'(pend.pop_front());
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      did_push = 1'b0;
      if (cap) begin
        if (mq.size() < DEP) begin
          e.r   = r_in;
          e.phi = phi_in;
          mq.push_back(e);
          did_push = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
`ifdef CORDIC_PEAK_TRACK_EN
      if (did_push && (peak_clr || ($signed(r_in) > $signed(m_peak)))) m_peak = r_in;
      else if (peak_clr) m_peak = '0;
`endif
      if (in_valid) pend.push_back(cyc + LAT);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int vals[4];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; peak_clr = 1'b0;
    r_in = '0; phi_in = '0;
    cyc = 0; pulse_cyc = 0; first_valid = 0; dut_pops = 0; saw_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset();

    // Single sample: latency LAT+1, then pop back to empty.
    r_in = 32'd70710; phi_in = 32'd450000;
    in_valid = 1'b1; pulse_cyc = cyc; first_valid = -1;
    tick();
    in_valid = 1'b0;
    repeat (LAT + 6) tick();
    chk("single_latency", 64'(first_valid), 64'(LAT + 1));
    chk("single_count", 64'(count), 64'd1);
    chk("single_r", 64'(out_r), 64'd70710);
    chk("single_phi", 64'(out_phi), 64'd450000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_popped_count", 64'(count), 64'd0);
    chk("single_popped_r", 64'(out_r), 64'd0);

    // Burst of 10 into a DEPTH-8 FIFO with no consumer.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; r_in = $urandom; phi_in = $urandom;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 4) begin
      r_in = $urandom; phi_in = $urandom;
      tick();
    end
    chk("burst_count", 64'(count), 64'(DEP));
    chk("burst_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    repeat (DEP + 2) tick();
    out_ready = 1'b0;
    chk("burst_drained", 64'(count), 64'd0);
    chk("burst_ovf_sticky", 64'(overflow), 64'd1);
    do_reset();

    // Full FIFO with a pop in the capture cycle.
    for (int i = 0; i < DEP; i++) begin
      in_valid = 1'b1; r_in = $urandom; phi_in = $urandom;
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("fullpop_filled", 64'(count), 64'(DEP));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (LAT - 1) tick();
    out_ready = 1'b1; r_in = 32'h1234_5678; phi_in = 32'h0abc_def0;
    tick();
    out_ready = 1'b0;
    chk("fullpop_count", 64'(count), 64'(DEP));
    chk("fullpop_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    repeat (DEP + 2) tick();
    out_ready = 1'b0;

    // Reset mid-stream discards in-flight samples.
    for (int j = 0; j < 6; j++) begin
      in_valid = (j < 3);
      rst = (j == 5);
      r_in = $urandom; phi_in = $urandom;
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; saw_valid = 1'b0;
    repeat (40) begin
      r_in = $urandom;
      tick();
    end
    chk("rst_mid_no_valid", 64'(saw_valid), 64'd0);
    chk("rst_mid_count", 64'(count), 64'd0);
    chk("rst_mid_overflow", 64'(overflow), 64'd0);

    // Peak tracking sequence: 100, 300, 300, 200, then clear with a capture of 50.
    vals[0] = 100; vals[1] = 300; vals[2] = 300; vals[3] = 200;
    out_ready = 1'b1;
    for (int j = 0; j < LAT + 8; j++) begin
      in_valid = (j < 4) || (j == 5);
      peak_clr = (j == LAT + 5);
      if (j >= LAT && j < LAT + 4) r_in = 32'(vals[j-LAT]);
      else if (j == LAT + 5)       r_in = 32'd50;
      else                         r_in = $urandom;
      phi_in = $urandom;
      tick();
      if (j == LAT + 3) begin
`ifdef CORDIC_PEAK_TRACK_EN
        chk("peak_max", 64'(peak_r), 64'd300);
`else
        chk("peak_off", 64'(peak_r), 64'd0);
`endif
      end
    end
    peak_clr = 1'b0;
`ifdef CORDIC_PEAK_TRACK_EN
    chk("peak_clr_push", 64'(peak_r), 64'd50);
`else
    chk("peak_off_end", 64'(peak_r), 64'd0);
`endif
    do_reset();

    // Wrap-around: 3*DEPTH+3 results with out_ready toggling.
    dut_pops = 0;
    for (int j = 0; j < 2 * (3 * DEP + 3); j++) begin
      in_valid = (j % 2 == 0);
      out_ready = (j % 2 == 1);
      r_in = $urandom; phi_in = $urandom;
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 2 * LAT + 8; j++) begin
      out_ready = (j % 2 == 1);
      r_in = $urandom; phi_in = $urandom;
      tick();
    end
    chk("wrap_pops", 64'(dut_pops), 64'(3 * DEP + 3));
    chk("wrap_overflow", 64'(overflow), 64'd0);

    // Random traffic with occasional resets and peak clears.
    for (int j = 0; j < 400; j++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      peak_clr  = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      r_in = $urandom; phi_in = $urandom;
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; peak_clr = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
